// File: rtl/abc_ram_loader_pkg.sv
// Shared constants for the CoreABC RAM loader: register map, CTRL/STATUS bits,
// fill FSM encoding and default RAM geometry.
package abc_ram_loader_pkg;

  localparam int RAM_DEPTH_DEF = 256;
  localparam int RAM_WIDTH_DEF = 8;
  localparam int APB_AW        = 5;

  // Word indices taken from PADDR[4:2]
  localparam logic [2:0] REG_PTR     = 3'd0;
  localparam logic [2:0] REG_DATA    = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_FILLVAL = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  localparam int CTRL_AUTOINC    = 0;
  localparam int CTRL_START_FILL = 1;

  localparam int STAT_FILL_BUSY = 0;
  localparam int STAT_WRAP      = 1;
  localparam int STAT_ABORT     = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/abc_ram_apb_loader_if.sv
// APB3 bus bundle between the host CPU bridge (master) and the RAM loader (slave).
interface abc_ram_apb_loader_if
  import abc_ram_loader_pkg::*;
#(
  parameter int DW = RAM_WIDTH_DEF,
  parameter int AW = APB_AW
);

  // A transfer is setup (PSEL & !PENABLE) then access (PSEL & PENABLE); it completes
  // in the access cycle where PREADY=1, and PRDATA/PSLVERR are valid only in that cycle.
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/abc_ram_fill_engine.sv
// Walks every RAM address once, writing the fill value; abandons the sweep the
// moment the ABC core becomes active.
module abc_ram_fill_engine
  import abc_ram_loader_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          core_active,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic          abort,
  output fill_state_e   state
);

  fill_state_e   state_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    wen     = 1'b0;
    abort   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !core_active) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        // The core owns the RAM from the cycle it goes active: no write this cycle.
        if (core_active) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          wen   = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign waddr = cnt_q;

endmodule

// File: rtl/abc_ram_apb_loader.sv
// APB3 slave giving the host load/readback access to the CoreABC RAM, with an
// auto-incrementing pointer and a hardware fill engine.
module abc_ram_apb_loader
  import abc_ram_loader_pkg::*;
#(
  parameter int RAM_DEPTH   = RAM_DEPTH_DEF,
  parameter int RAM_WIDTH   = RAM_WIDTH_DEF,
  parameter bit AUTOINC_RST = 1'b1,
  localparam int AW         = $clog2(RAM_DEPTH)
) (
  input  logic                 PCLK,
  input  logic                 NSYSRESET,
  abc_ram_apb_loader_if.slave  apb,
  input  logic                 CORE_ACTIVE,
  output logic                 RAM_WEN,
  output logic [AW-1:0]        RAM_WADDR,
  output logic [RAM_WIDTH-1:0] RAM_WD,
  output logic                 RAM_REN,
  output logic [AW-1:0]        RAM_RADDR,
  input  logic [RAM_WIDTH-1:0] RAM_RD,
  output logic                 FILL_BUSY
);

  logic [2:0]           reg_idx;
  logic                 setup_ph;
  logic                 access_ph;
  logic                 data_acc;
  logic                 data_rej;
  logic                 data_ok;
  logic [AW-1:0]        ptr_q;
  logic                 autoinc_q;
  logic [RAM_WIDTH-1:0] fillval_q;
  logic                 wrap_q;
  logic                 abort_q;
  logic                 fill_start;
  logic                 fill_wen;
  logic                 fill_abort;
  logic [AW-1:0]        fill_addr;
  fill_state_e          fill_state;
  logic                 unused_addr_bits;

  assign reg_idx          = apb.PADDR[4:2];
  assign unused_addr_bits = ^apb.PADDR[1:0];
  assign setup_ph         = apb.PSEL & ~apb.PENABLE;
  assign access_ph        = apb.PSEL & apb.PENABLE;

  // DATA is refused while the engine owns the RAM, and writes while the core runs.
  assign data_acc = access_ph & (reg_idx == REG_DATA);
  assign data_rej = data_acc & (FILL_BUSY | (apb.PWRITE & CORE_ACTIVE));
  assign data_ok  = data_acc & ~data_rej;

  assign fill_start = access_ph & apb.PWRITE & (reg_idx == REG_CTRL)
                    & apb.PWDATA[CTRL_START_FILL];

  abc_ram_fill_engine #(.AW(AW)) u_fill (
    .clk         (PCLK),
    .rst_n       (NSYSRESET),
    .start       (fill_start),
    .core_active (CORE_ACTIVE),
    .wen         (fill_wen),
    .waddr       (fill_addr),
    .abort       (fill_abort),
    .state       (fill_state)
  );

  assign FILL_BUSY = (fill_state == ST_FILL);

  always_ff @(posedge PCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      ptr_q     <= '0;
      autoinc_q <= AUTOINC_RST;
      fillval_q <= '0;
      wrap_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      if (access_ph && apb.PWRITE) begin
        case (reg_idx)
          REG_PTR: begin
            ptr_q   <= AW'(apb.PWDATA);
            wrap_q  <= 1'b0;
            abort_q <= 1'b0;
          end
          REG_CTRL:    autoinc_q <= apb.PWDATA[CTRL_AUTOINC];
          REG_FILLVAL: fillval_q <= apb.PWDATA;
          default: ;
        endcase
      end
      if (data_ok && autoinc_q) begin
        ptr_q <= ptr_q + 1'b1;
        if (ptr_q == '1) wrap_q <= 1'b1;
      end
      if (fill_abort) abort_q <= 1'b1;
    end
  end

  // RAM write port: the fill engine wins; host DATA writes are rejected during a fill anyway.
  always_comb begin
    RAM_WEN   = 1'b0;
    RAM_WADDR = ptr_q;
    RAM_WD    = apb.PWDATA;
    if (fill_wen) begin
      RAM_WEN   = 1'b1;
      RAM_WADDR = fill_addr;
      RAM_WD    = fillval_q;
    end else if (data_ok && apb.PWRITE) begin
      RAM_WEN = 1'b1;
    end
  end

  // Reads are launched in the setup phase so RAM_RD is ready for the access phase.
  assign RAM_REN   = setup_ph & ~apb.PWRITE & (reg_idx == REG_DATA) & ~FILL_BUSY;
  assign RAM_RADDR = ptr_q;

  always_comb begin
    apb.PRDATA = '0;
    if (access_ph && !apb.PWRITE) begin
      case (reg_idx)
        REG_PTR:     apb.PRDATA = RAM_WIDTH'(ptr_q);
        REG_DATA:    if (data_ok) apb.PRDATA = RAM_RD;
        REG_CTRL:    apb.PRDATA[CTRL_AUTOINC] = autoinc_q;
        REG_FILLVAL: apb.PRDATA = fillval_q;
        REG_STATUS: begin
          apb.PRDATA[STAT_FILL_BUSY] = FILL_BUSY;
          apb.PRDATA[STAT_WRAP]      = wrap_q;
          apb.PRDATA[STAT_ABORT]     = abort_q;
        end
        default: ;
      endcase
    end
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = data_rej;

endmodule

// File: tb/tb_abc_ram_apb_loader.sv
// Directed bench for abc_ram_apb_loader: APB driver tasks, a behavioural 256x8 RAM,
// a host-write scoreboard and a final report.
module tb_abc_ram_apb_loader;

  localparam logic [4:0] A_PTR     = 5'h00;
  localparam logic [4:0] A_DATA    = 5'h04;
  localparam logic [4:0] A_CTRL    = 5'h08;
  localparam logic [4:0] A_FILLVAL = 5'h0C;
  localparam logic [4:0] A_STATUS  = 5'h10;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic nsysreset = 1'b0;
  logic core_active = 1'b0;
  always #5 pclk = ~pclk;

  logic       ram_wen, ram_ren, fill_busy;
  logic [7:0] ram_waddr, ram_wd, ram_raddr, ram_rd;

  abc_ram_apb_loader_if apb();

  abc_ram_apb_loader dut (
    .PCLK        (pclk),
    .NSYSRESET   (nsysreset),
    .apb         (apb),
    .CORE_ACTIVE (core_active),
    .RAM_WEN     (ram_wen),
    .RAM_WADDR   (ram_waddr),
    .RAM_WD      (ram_wd),
    .RAM_REN     (ram_ren),
    .RAM_RADDR   (ram_raddr),
    .RAM_RD      (ram_rd),
    .FILL_BUSY   (fill_busy)
  );

  // ---------------- RAM model and monitors ----------------
  logic [7:0] mem [256];
  always @(posedge pclk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wd;
    if (ram_ren) ram_rd <= mem[ram_raddr];
  end

  logic [15:0] wr_log[$];
  int busy_total = 0;
  int ren_total  = 0;
  int ren_setup  = 0;
  always @(negedge pclk) begin
    if (nsysreset && ram_wen && !fill_busy) wr_log.push_back({ram_waddr, ram_wd});
    if (fill_busy) busy_total++;
    if (ram_ren) begin
      ren_total++;
      if (apb.PSEL && !apb.PENABLE) ren_setup++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int wr_idx = 0;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drain_writes(input string tag);
    logic [15:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, (wr_idx < wr_log.size()) ? {16'h0, wr_log[wr_idx]} : 32'hFFFF_FFFF, {16'h0, e});
      wr_idx++;
    end
    check({tag, "_count"}, wr_log.size(), wr_idx);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [4:0] a, input logic [7:0] d, output logic err);
    @(posedge pclk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d;
    @(posedge pclk); #1;
    apb.PENABLE = 1'b1;
    @(negedge pclk);
    err = apb.PSLVERR;
    check("pready_wr", apb.PREADY, 1'b1);
    @(posedge pclk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [7:0] d, output logic err);
    @(posedge pclk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
    @(posedge pclk); #1;
    apb.PENABLE = 1'b1;
    @(negedge pclk);
    d = apb.PRDATA;
    err = apb.PSLVERR;
    check("pready_rd", apb.PREADY, 1'b1);
    @(posedge pclk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [7:0] d, input logic exp_err);
    logic e;
    apb_write(a, d, e);
    check({tag, "_slverr"}, e, exp_err);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp_d);
    logic [7:0] d;
    logic e;
    apb_read(a, d, e);
    check(tag, d, exp_d);
    check({tag, "_slverr"}, e, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic e;
    int b0, r0, s0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;

    repeat (3) @(posedge pclk);
    #2;
    check("rst_ram_wen", ram_wen, 1'b0);
    check("rst_ram_ren", ram_ren, 1'b0);
    check("rst_fill_busy", fill_busy, 1'b0);
    check("rst_pslverr", apb.PSLVERR, 1'b0);
    check("rst_prdata", apb.PRDATA, 8'h00);
    @(negedge pclk) nsysreset = 1'b1;
    rd("rst_ctrl", A_CTRL, 8'h01);
    rd("rst_ptr", A_PTR, 8'h00);
    rd("rst_fillval", A_FILLVAL, 8'h00);
    rd("rst_status", A_STATUS, 8'h00);

    // Host writes with auto-increment
    wr("ptr10", A_PTR, 8'h10, 1'b0);
    exp_q.push_back({8'h10, 8'hA1});
    exp_q.push_back({8'h11, 8'hA2});
    exp_q.push_back({8'h12, 8'hA3});
    wr("data_a1", A_DATA, 8'hA1, 1'b0);
    wr("data_a2", A_DATA, 8'hA2, 1'b0);
    wr("data_a3", A_DATA, 8'hA3, 1'b0);
    drain_writes("host_wr");
    rd("ptr_after_wr", A_PTR, 8'h13);

    // Host readback, RAM_REN only in setup phases
    wr("ptr10b", A_PTR, 8'h10, 1'b0);
    r0 = ren_total; s0 = ren_setup;
    rd("data_rd0", A_DATA, 8'hA1);
    rd("data_rd1", A_DATA, 8'hA2);
    rd("data_rd2", A_DATA, 8'hA3);
    check("ren_count", ren_total - r0, 3);
    check("ren_setup_only", ren_setup - s0, 3);
    rd("ptr_after_rd", A_PTR, 8'h13);

    // Unmapped addresses
    rd("unmapped_14", 5'h14, 8'h00);
    wr("unmapped_wr18", 5'h18, 8'hFF, 1'b0);
    rd("unmapped_1c", 5'h1C, 8'h00);
    rd("unmapped_ptr", A_PTR, 8'h13);
    rd("unmapped_fillval", A_FILLVAL, 8'h00);
    rd("unmapped_ctrl", A_CTRL, 8'h01);

    // Pointer wrap, sticky WRAP cleared by PTR write
    wr("ptrff", A_PTR, 8'hFF, 1'b0);
    exp_q.push_back({8'hFF, 8'h77});
    wr("data_77", A_DATA, 8'h77, 1'b0);
    drain_writes("wrap_wr");
    rd("ptr_wrapped", A_PTR, 8'h00);
    rd("status_wrap", A_STATUS, 8'h02);
    wr("ptr05", A_PTR, 8'h05, 1'b0);
    rd("status_cleared", A_STATUS, 8'h00);

    // Auto-increment disabled
    wr("ctrl_noinc", A_CTRL, 8'h00, 1'b0);
    exp_q.push_back({8'h05, 8'h99});
    wr("data_99", A_DATA, 8'h99, 1'b0);
    drain_writes("noinc_wr");
    rd("ptr_noinc", A_PTR, 8'h05);
    wr("ctrl_inc", A_CTRL, 8'h01, 1'b0);

    // Full fill
    wr("fillval5a", A_FILLVAL, 8'h5A, 1'b0);
    b0 = busy_total;
    wr("start_fill", A_CTRL, 8'h03, 1'b0);
    check("fill_busy_start", fill_busy, 1'b1);
    apb_read(A_DATA, d, e);
    check("fill_data_rd_slverr", e, 1'b1);
    wr("fill_data_wr", A_DATA, 8'h11, 1'b1);
    rd("fill_ptr_rd", A_PTR, 8'h05);
    rd("fill_status", A_STATUS, 8'h01);
    for (int i = 0; i < 400 && fill_busy; i++) @(negedge pclk);
    check("fill_done", fill_busy, 1'b0);
    check("fill_len", busy_total - b0, 256);
    drain_writes("fill_no_host_wr");
    wr("ptr00", A_PTR, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) rd($sformatf("fill_%02h", i), A_DATA, 8'h5A);
    rd("status_after_dump", A_STATUS, 8'h02);

    // Fill aborted by CORE_ACTIVE at fill cycle 40
    wr("ptr00b", A_PTR, 8'h00, 1'b0);
    wr("fillvalc3", A_FILLVAL, 8'hC3, 1'b0);
    wr("start_fill2", A_CTRL, 8'h03, 1'b0);
    repeat (40) @(posedge pclk);
    #1 core_active = 1'b1;
    @(negedge pclk);
    check("abort_no_wen", ram_wen, 1'b0);
    check("abort_busy_still", fill_busy, 1'b1);
    @(posedge pclk); #1;
    check("abort_busy_drop", fill_busy, 1'b0);
    rd("status_abort", A_STATUS, 8'h04);
    wr("start_while_core", A_CTRL, 8'h03, 1'b0);
    @(negedge pclk);
    check("start_while_core_idle", fill_busy, 1'b0);
    wr("core_data_wr", A_DATA, 8'hEE, 1'b1);
    rd("core_data_rd", A_DATA, 8'hC3);
    drain_writes("abort_no_host_wr");
    wr("ptr00c", A_PTR, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++)
      rd($sformatf("abort_%02h", i), A_DATA, (i < 40) ? 8'hC3 : 8'h5A);
    rd("status_after_abort_dump", A_STATUS, 8'h02);

    // Reset in the middle of a fill
    core_active = 1'b0;
    wr("ctrl_noinc2", A_CTRL, 8'h00, 1'b0);
    wr("ptr33", A_PTR, 8'h33, 1'b0);
    wr("fillval77", A_FILLVAL, 8'h77, 1'b0);
    wr("start_fill3", A_CTRL, 8'h02, 1'b0);
    repeat (10) @(posedge pclk);
    #3 nsysreset = 1'b0;
    #1;
    check("midrst_ram_wen", ram_wen, 1'b0);
    check("midrst_fill_busy", fill_busy, 1'b0);
    check("midrst_pslverr", apb.PSLVERR, 1'b0);
    check("midrst_prdata", apb.PRDATA, 8'h00);
    repeat (2) @(negedge pclk);
    nsysreset = 1'b1;
    rd("midrst_ctrl", A_CTRL, 8'h01);
    rd("midrst_ptr", A_PTR, 8'h00);
    rd("midrst_fillval", A_FILLVAL, 8'h00);
    rd("midrst_status", A_STATUS, 8'h00);

    drain_writes("final_wr");
    check("ren_total_setup", ren_setup, ren_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
